// File: rtl/sm4_key_expansion.sv
// SM4 key expansion: turns a 128-bit master key into the 32 forward-order
// round keys. It computes one round per clock and uses a single S-box layer
// of four byte lookups.
//
// Handshake: the requester pulses key_start_in for one cycle while the block
// is idle (busy_out = 0). A pulse while busy_out = 1 is ignored. When
// key_exp_ready_out = 1, rk_data_out holds a complete schedule, and it stays
// valid until the next accepted start. While ready = 0 the slices may be
// only partly updated.
module sm4_key_expansion (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [127:0]  key_in,
  input  logic          key_start_in,
  output logic          busy_out,
  output logic          key_exp_ready_out,
  output logic [1023:0] rk_data_out
);

  typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_t;

  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] k0, k1, k2, k3;
  logic [31:0] ck, x, b, rk_new;
  logic [7:0]  ck_base;

  assign busy_out = (state == EXPAND);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: a start is accepted only from IDLE; leave EXPAND after round 31.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key_start_in) state_nxt = EXPAND;
      EXPAND:  if (cnt == 5'd31) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Round function: CK generated on the fly (byte j = (4i+j)*7 mod 256), then S-box and linear mix.
  always_comb begin
    ck_base = {1'b0, cnt, 2'b00};
    ck[31:24] = 8'((ck_base + 8'd0) * 8'd7);
    ck[23:16] = 8'((ck_base + 8'd1) * 8'd7);
    ck[15:8]  = 8'((ck_base + 8'd2) * 8'd7);
    ck[7:0]   = 8'((ck_base + 8'd3) * 8'd7);
    x = k1 ^ k2 ^ k3 ^ ck;
    b = {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    rk_new = k0 ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  end

  // Datapath: load the K window at start, then write one round key slice per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt               <= '0;
      k0                <= '0;
      k1                <= '0;
      k2                <= '0;
      k3                <= '0;
      rk_data_out       <= '0;
      key_exp_ready_out <= 1'b0;
    end else if (state == IDLE) begin
      if (key_start_in) begin
        {k0, k1, k2, k3}  <= key_in ^ FK;
        cnt               <= '0;
        key_exp_ready_out <= 1'b0;
      end
    end else begin
      rk_data_out[{cnt, 5'd0} +: 32] <= rk_new;
      {k0, k1, k2, k3} <= {k1, k2, k3, rk_new};
      cnt              <= cnt + 5'd1;
      if (cnt == 5'd31) key_exp_ready_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sm4_key_expansion.sv
// Directed bench for sm4_key_expansion: the standard test key, a start pulse
// ignored mid-run, restart after ready, asynchronous reset in the middle of an
// expansion, and back-to-back random keys compared against a reference
// model. The standard schedule is also cross-checked by encrypting and
// decrypting the standard test vector.
module tb_sm4_key_expansion;

  logic          clk;
  logic          reset_n;
  logic [127:0]  key_in;
  logic          key_start_in;
  logic          busy_out;
  logic          key_exp_ready_out;
  logic [1023:0] rk_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] KEY_A = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] KEY_B = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] PT    = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] CT    = 128'h681EDF34D206965E86B3E94F536E4246;
  localparam logic [127:0] FK    = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  sm4_key_expansion dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .key_in            (key_in),
    .key_start_in      (key_start_in),
    .busy_out          (busy_out),
    .key_exp_ready_out (key_exp_ready_out),
    .rk_data_out       (rk_data_out)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] v);
    return {SBOX[v[31:24]], SBOX[v[23:16]], SBOX[v[15:8]], SBOX[v[7:0]]};
  endfunction

  function automatic logic [1023:0] model_expand(input logic [127:0] mk);
    logic [31:0]   k [4];
    logic [31:0]   ck, bb, rk;
    logic [7:0]    cb;
    logic [1023:0] out;
    logic [127:0]  kw;
    kw = mk ^ FK;
    k[0] = kw[127:96]; k[1] = kw[95:64]; k[2] = kw[63:32]; k[3] = kw[31:0];
    out = '0;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) begin
        cb = 8'(((4 * i) + j) * 7);
        ck[31 - 8*j -: 8] = cb;
      end
      bb = tau(k[1] ^ k[2] ^ k[3] ^ ck);
      rk = k[0] ^ bb ^ rotl(bb, 13) ^ rotl(bb, 23);
      out[i*32 +: 32] = rk;
      k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = rk;
    end
    return out;
  endfunction

  // Block cipher built on a schedule; decryption uses the keys in reverse order.
  function automatic logic [127:0] sm4_crypt(input logic [127:0] din, input logic [1023:0] rks,
                                             input bit dec);
    logic [31:0] x [4];
    logic [31:0] r, bb, nx;
    x[0] = din[127:96]; x[1] = din[95:64]; x[2] = din[63:32]; x[3] = din[31:0];
    for (int i = 0; i < 32; i++) begin
      r  = dec ? rks[(31 - i)*32 +: 32] : rks[i*32 +: 32];
      bb = tau(x[1] ^ x[2] ^ x[3] ^ r);
      nx = x[0] ^ bb ^ rotl(bb, 2) ^ rotl(bb, 10) ^ rotl(bb, 18) ^ rotl(bb, 24);
      x[0] = x[1]; x[1] = x[2]; x[2] = x[3]; x[3] = nx;
    end
    return {x[3], x[2], x[1], x[0]};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: the expected schedule is queued word by word, then drained against the bus.
  logic [31:0] exp_q[$];

  task automatic check_schedule(input string tag, input logic [1023:0] exp_sched);
    logic [31:0] e;
    for (int i = 0; i < 32; i++) exp_q.push_back(exp_sched[i*32 +: 32]);
    for (int i = 0; i < 32; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s rk[%0d]", tag, i), 128'(rk_data_out[i*32 +: 32]), 128'(e));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start with key, run until busy drops (bounded). A second start
  // with glitch_key is pulsed after glitch_at cycles of EXPAND (-1 = none).
  task automatic run_expand(input logic [127:0] key, input int glitch_at,
                            input logic [127:0] glitch_key,
                            output int busy_cycles, output int ready_rises);
    logic prev_ready;
    key_in = key;
    key_start_in = 1'b1;
    tick();
    key_start_in = 1'b0;
    check("ready low after start edge", 128'(key_exp_ready_out), 128'(0));
    check("busy high after start edge", 128'(busy_out), 128'(1));
    busy_cycles = 0;
    ready_rises = 0;
    prev_ready  = key_exp_ready_out;
    while (busy_out && busy_cycles < 64) begin
      if (busy_cycles == glitch_at) begin
        key_in = glitch_key;
        key_start_in = 1'b1;
      end
      tick();
      key_start_in = 1'b0;
      busy_cycles++;
      if (key_exp_ready_out && !prev_ready) ready_rises++;
      prev_ready = key_exp_ready_out;
    end
    if (busy_cycles >= 64) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy timeout: busy still 1 after %0d cycles, required 0", busy_cycles);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1023:0] sched_a, sched_b, sched_r, snap;
    logic [127:0]  rkey;
    int bc, rr;

    sched_a = model_expand(KEY_A);
    sched_b = model_expand(KEY_B);

    reset_n = 1'b0;
    key_in = '0;
    key_start_in = 1'b0;
    tick();
    tick();
    check("reset busy", 128'(busy_out), 128'(0));
    check("reset ready", 128'(key_exp_ready_out), 128'(0));
    check("reset rk low", rk_data_out[127:0], 128'(0));
    check("reset rk high", rk_data_out[1023:896], 128'(0));
    reset_n = 1'b1;
    tick();

    // Standard key: latency, known round keys, and full schedule.
    run_expand(KEY_A, -1, '0, bc, rr);
    check("std busy cycles", 128'(bc), 128'(32));
    check("std ready", 128'(key_exp_ready_out), 128'(1));
    check("std rk0", 128'(rk_data_out[31:0]), 128'(32'hF12186F9));
    check("std rk1", 128'(rk_data_out[63:32]), 128'(32'h41662B61));
    check("std rk31", 128'(rk_data_out[1023:992]), 128'(32'h9124A012));
    check_schedule("std", sched_a);
    check("std encrypt", sm4_crypt(PT, rk_data_out, 1'b0), CT);
    check("std decrypt", sm4_crypt(CT, rk_data_out, 1'b1), PT);

    // Start during EXPAND with a different key is ignored.
    tick();
    run_expand(KEY_A, 10, KEY_B, bc, rr);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (key_exp_ready_out !== 1'b1) rr++;
    end
    check("ignore busy cycles", 128'(bc), 128'(32));
    check("ignore ready rises", 128'(rr), 128'(1));
    check_schedule("ignore", sched_a);

    // key_in change without start has no effect; then restart with new key.
    snap = rk_data_out;
    key_in = KEY_B;
    for (int i = 0; i < 5; i++) tick();
    check("hold ready", 128'(key_exp_ready_out), 128'(1));
    check("hold rk low", rk_data_out[511:384], snap[511:384]);
    check("hold rk high", rk_data_out[1023:896], snap[1023:896]);
    run_expand(KEY_B, -1, '0, bc, rr);
    check("restart busy cycles", 128'(bc), 128'(32));
    check("restart ready", 128'(key_exp_ready_out), 128'(1));
    check_schedule("restart", sched_b);

    // Asynchronous reset partway through an expansion.
    tick();
    key_in = KEY_A;
    key_start_in = 1'b1;
    tick();
    key_start_in = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst busy", 128'(busy_out), 128'(0));
    check("async rst ready", 128'(key_exp_ready_out), 128'(0));
    check("async rst rk0", rk_data_out[127:0], 128'(0));
    check("async rst rk mid", rk_data_out[639:512], 128'(0));
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    run_expand(KEY_A, -1, '0, bc, rr);
    check("post rst busy cycles", 128'(bc), 128'(32));
    check_schedule("post rst", sched_a);

    // Back-to-back random keys, each started on the first idle cycle.
    for (int n = 0; n < 4; n++) begin
      rkey = {$urandom(), $urandom(), $urandom(), $urandom_range(32'hFFFF_FFFF, 0)};
      sched_r = model_expand(rkey);
      run_expand(rkey, -1, '0, bc, rr);
      check($sformatf("b2b%0d busy cycles", n), 128'(bc), 128'(32));
      check($sformatf("b2b%0d ready", n), 128'(key_exp_ready_out), 128'(1));
      check_schedule($sformatf("b2b%0d", n), sched_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
